// File: rtl/condlogic_mt.sv
// Multi-context ARM condition unit: per-context NZCV and shadow flags, condition
// evaluation with write gating, stall/flush/save/restore and saturating counters.
module condlogic_mt #(
    parameter int NCTX = 4,
    parameter int CTXW = (NCTX > 1) ? $clog2(NCTX) : 1,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [CTXW-1:0] ctx,
    input  logic [3:0]      Cond,
    input  logic [3:0]      ALUFlags,
    input  logic [1:0]      FlagW,
    input  logic            PCS,
    input  logic            RegW,
    input  logic            MemW,
    input  logic            stall,
    input  logic            flush,
    input  logic            save,
    input  logic            restore,
    output logic            CondEx,
    output logic            PCSrc,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic [3:0]      Flags,
    output logic [CNTW-1:0] exec_cnt,
    output logic [CNTW-1:0] skip_cnt
);

    logic [3:0] flags  [NCTX];
    logic [3:0] shadow [NCTX];

    logic [3:0] cur;
    logic [3:0] shcur;
    logic [3:0] nextflags;
    logic       hit;
    logic       base;
    logic       pass;
    logic       act;
    logic       upd;

    // Out-of-range context indices read as zero flags and never match a register.
    always_comb begin
        cur   = 4'b0000;
        shcur = 4'b0000;
        hit   = 1'b0;
        for (int i = 0; i < NCTX; i++) begin
            if (ctx == CTXW'(i)) begin
                cur   = flags[i];
                shcur = shadow[i];
                hit   = 1'b1;
            end
        end
    end

    // Odd condition codes are the complement of the even one below them; 1111 falls
    // out as the complement of AL.
    always_comb begin
        base = 1'b0;
        unique case (Cond[3:1])
            3'b000:  base = cur[2];
            3'b001:  base = cur[1];
            3'b010:  base = cur[3];
            3'b011:  base = cur[0];
            3'b100:  base = cur[1] & ~cur[2];
            3'b101:  base = (cur[3] == cur[0]);
            3'b110:  base = ~cur[2] & (cur[3] == cur[0]);
            default: base = 1'b1;
        endcase
        pass = base ^ Cond[0];
    end

    assign act      = valid & ~flush & hit;
    assign upd      = act & ~stall;
    assign CondEx   = act & pass;
    assign RegWrite = RegW & CondEx;
    assign MemWrite = MemW & CondEx;
    assign PCSrc    = PCS & CondEx;
    assign Flags    = cur;

    always_comb begin
        nextflags = cur;
        if (CondEx && FlagW[1]) nextflags[3:2] = ALUFlags[3:2];
        if (CondEx && FlagW[0]) nextflags[1:0] = ALUFlags[1:0];
        if (restore)            nextflags      = shcur;
    end

    // Save always captures the pre-update flags, so save+restore swaps the pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCTX; i++) begin
                flags[i]  <= 4'b0000;
                shadow[i] <= 4'b0000;
            end
            exec_cnt <= '0;
            skip_cnt <= '0;
        end else if (upd) begin
            for (int i = 0; i < NCTX; i++) begin
                if (ctx == CTXW'(i)) begin
                    flags[i] <= nextflags;
                    if (save) shadow[i] <= cur;
                end
            end
            if (pass) begin
                if (exec_cnt != '1) exec_cnt <= exec_cnt + 1'b1;
            end else begin
                if (skip_cnt != '1) skip_cnt <= skip_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_condlogic_mt.sv
// Randomized and directed bench for condlogic_mt against a flag-table reference model.
module tb_condlogic_mt;

    localparam int NCTX = 3;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic       clk;
    logic       reset;
    logic       valid;
    logic [1:0] ctx;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, stall, flush, save, restore;
    logic       CondEx, PCSrc, RegWrite, MemWrite;
    logic [3:0] Flags;
    logic [CNTW-1:0] exec_cnt, skip_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0] mflags  [NCTX];
    logic [3:0] mshadow [NCTX];
    int mexec, mskip;

    condlogic_mt #(.NCTX(NCTX), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .valid(valid), .ctx(ctx), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .stall(stall), .flush(flush), .save(save), .restore(restore),
        .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Flags(Flags), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Direct transcription of the ARM condition table.
    function automatic logic condModel(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic [1:0] c,
                                 input logic [3:0] cc, input logic [3:0] alu,
                                 input logic [1:0] fw, input logic pcs, input logic regw,
                                 input logic memw, input logic st, input logic fl,
                                 input logic sv, input logic rs);
        logic [3:0] cf, nf;
        logic inr, act, pass, cex;
        reset = rst; valid = v; ctx = c; Cond = cc; ALUFlags = alu; FlagW = fw;
        PCS = pcs; RegW = regw; MemW = memw; stall = st; flush = fl; save = sv; restore = rs;
        #1;
        inr  = (int'(c) < NCTX);
        cf   = inr ? mflags[c] : 4'b0000;
        pass = condModel(cc, cf);
        act  = v && !fl && inr;
        cex  = act && pass;
        checkOutput("CondEx",   16'(CondEx),   16'(cex));
        checkOutput("RegWrite", 16'(RegWrite), 16'(cex && regw));
        checkOutput("MemWrite", 16'(MemWrite), 16'(cex && memw));
        checkOutput("PCSrc",    16'(PCSrc),    16'(cex && pcs));
        checkOutput("Flags",    16'(Flags),    16'(cf));
        checkOutput("exec_cnt", 16'(exec_cnt), 16'(mexec));
        checkOutput("skip_cnt", 16'(skip_cnt), 16'(mskip));
        if (rst) begin
            for (int i = 0; i < NCTX; i++) begin
                mflags[i] = 4'b0000;
                mshadow[i] = 4'b0000;
            end
            mexec = 0;
            mskip = 0;
        end else if (act && !st) begin
            nf = cf;
            if (cex && fw[1]) nf[3:2] = alu[3:2];
            if (cex && fw[0]) nf[1:0] = alu[1:0];
            if (rs) nf = mshadow[c];
            if (sv) mshadow[c] = cf;
            mflags[c] = nf;
            if (pass) mexec = (mexec == CMAX) ? CMAX : mexec + 1;
            else      mskip = (mskip == CMAX) ? CMAX : mskip + 1;
        end
        @(negedge clk);
    endtask

    task automatic op(input logic [1:0] c, input logic [3:0] cc, input logic [3:0] alu,
                      input logic [1:0] fw);
        applyStimulus(0, 1, c, cc, alu, fw, 1, 1, 1, 0, 0, 0, 0);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NCTX; i++) begin
            mflags[i] = 4'b0000;
            mshadow[i] = 4'b0000;
        end
        mexec = 0;
        mskip = 0;

        // EQ fails on zero flags, NE passes
        op(0, 4'b0000, 4'b0000, 2'b00);
        op(0, 4'b0001, 4'b0000, 2'b00);
        // ctx1 gets Z, ctx0 untouched
        op(1, 4'b1110, 4'b0100, 2'b11);
        op(1, 4'b0000, 4'b0000, 2'b00);
        op(0, 4'b0000, 4'b0000, 2'b00);
        // ctx2 N set: LT passes, GE fails
        op(2, 4'b1110, 4'b1000, 2'b11);
        op(2, 4'b1011, 4'b0000, 2'b00);
        op(2, 4'b1010, 4'b0000, 2'b00);
        // save / modify / restore-overrides-write
        op(0, 4'b1110, 4'b0010, 2'b11);
        applyStimulus(0, 1, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        op(0, 4'b1110, 4'b1101, 2'b11);
        applyStimulus(0, 1, 0, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 0, 1);
        op(0, 4'b1110, 4'b0000, 2'b00);
        // swap: flags 0010 / shadow 0010 -> write 0001 then save+restore
        op(0, 4'b1110, 4'b0001, 2'b11);
        applyStimulus(0, 1, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        // stall, flush, out-of-range ctx
        applyStimulus(0, 1, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 1, 0, 1, 1);
        applyStimulus(0, 1, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 1, 1);
        applyStimulus(0, 1, 3, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 1, 1);
        op(0, 4'b1110, 4'b0000, 2'b00);
        // counter saturation, then mid-stream reset
        for (int i = 0; i < 20; i++) op(2'(i % NCTX), 4'b1110, 4'(i), 2'(i));
        applyStimulus(1, 1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 1, 0);
        op(1, 4'b0001, 4'b0000, 2'b00);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 7) != 0),
                          2'($urandom_range(0, 3)),
                          4'($urandom), 4'($urandom), 2'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/condlogic_mt.md
Name: condlogic_mt

Overview:
Multi-context ARM condition unit and successor to the single-context condition logic. Holds NCTX independent NZCV flag registers plus one shadow (saved) flag register per context. Evaluates the 4-bit condition field against the selected context's flags and gates RegW/MemW/PCS/FlagW. Sits in the execute stage of the multithreaded datapath and adds stall, flush and save/restore handling, and saturating executed/skipped counters.

Parameters:
NCTX, 4, number of hardware contexts (≥1)
CTXW, $clog2(NCTX) (min 1), context-index width
CNTW, 16, width of each performance counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
valid  in  1  instruction present this cycle
ctx  in  CTXW  context index of the instruction; values ≥ NCTX are treated as valid=0
Cond  in  4  ARM condition field
ALUFlags  in  4  {N,Z,C,V} from the ALU
FlagW  in  2  [1]=write N,Z; [0]=write C,V
PCS  in  1  instruction writes PC
RegW  in  1  instruction writes a register
MemW  in  1  instruction writes memory
stall  in  1  hold; no state update
flush  in  1  squash the current instruction
save  in  1  copy ctx flags to its shadow
restore  in  1  load ctx flags from its shadow
CondEx  out  1  condition passed (combinational)
PCSrc  out  1  PCS gated (combinational)
RegWrite  out  1  RegW gated (combinational)
MemWrite  out  1  MemW gated (combinational)
Flags  out  4  current stored flags of ctx (combinational read)
exec_cnt  out  CNTW  instructions whose condition passed
skip_cnt  out  CNTW  instructions whose condition failed

Behaviour:
- Reset: all flag and shadow registers = 4'b0000; exec_cnt = skip_cnt = 0. Combinational outputs then follow from zero flags.
- Flags = flag register of ctx. Cond is evaluated against stored flags only; there is no same-cycle forwarding of ALUFlags.
- Condition codes:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 never 0
- Define act = valid & !flush & (ctx<NCTX).
- CondEx = act & cond_pass.
- RegWrite = RegW&CondEx; MemWrite = MemW&CondEx; PCSrc = PCS&CondEx. stall does not mask these; downstream stall logic owns that.
- Define upd = act & !stall. All register updates below occur at the clock edge and only when upd=1.
- Flag write: if CondEx, flags[ctx][3:2] <= ALUFlags[3:2] when FlagW[1]; flags[ctx][1:0] <= ALUFlags[1:0] when FlagW[0]. Other contexts are never touched.
- save: shadow[ctx] <= flags[ctx], using the pre-update value. save is unconditional w.r.t. Cond.
- restore: flags[ctx] <= shadow[ctx], using the pre-update value. restore overrides any FlagW write in the same cycle.
- save & restore together: swap flags[ctx] and shadow[ctx].
- Counters: exec_cnt += 1 when upd & cond_pass; skip_cnt += 1 when upd & !cond_pass. Both saturate at 2^CNTW−1 and do not wrap.
- Back-to-back instructions on the same ctx: the second sees flags written by the first, with one-cycle latency through the register.
- stall=1: all state holds; combinational outputs remain valid.
- flush=1: CondEx=0, no updates, no counting.
- reset asserted mid-stream overrides every other input in that cycle.

Test Plan:
- Reset, then valid ctx=0 Cond=0000 (EQ) → CondEx=0, Flags=0000. Next cycle, ctx=0 Cond=0001 (NE) → CondEx=1, skip_cnt=1, exec_cnt=1.
- ctx=1 AL, FlagW=11, ALUFlags=0100 → next cycle ctx=1 Flags=0100 and EQ passes; ctx=0 Flags remain 0000.
- ctx=2 flags=1000, Cond=1011 (LT) with RegW=1, MemW=1, PCS=1 → CondEx=1, all three gated outputs 1. Cond=1010 (GE) → all 0; skip_cnt increments.
- ctx=0 flags=0010, save → change flags to 1101 via FlagW=11 → restore with FlagW=11, ALUFlags=1111 in the same cycle → Flags=0010.
- stall=1 with FlagW=11, ALUFlags=1111 → flags and counters unchanged. flush=1 → CondEx=0, nothing changes. ctx=NCTX → treated as invalid.
- CNTW=4: drive 20 passing instructions → exec_cnt holds at 15. Assert reset mid-sequence → all flags, shadows and counters return to 0 on the next edge.
